// File: rtl/regfile_readback_checker_if.sv
// Bus between the readback checker and its register source / result consumer.
interface regfile_readback_checker_if;
  logic        start;
  logic [15:0] regReadData;
  logic [5:0]  regReadNumber;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  errCount;
  logic [5:0]  failReg;

  modport master (
    output start, regReadData,
    input  regReadNumber, result, busy, done, pass, errCount, failReg
  );

  modport slave (
    input  start, regReadData,
    output regReadNumber, result, busy, done, pass, errCount, failReg
  );
endinterface

// File: rtl/regfile_readback_checker.sv
// Scans registers 0..NUM_REGS-1, compares each against a linear expected pattern,
// and holds every captured value on result for DWELL cycles so it can be observed.
module regfile_readback_checker #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DWELL    = 50000000,
  parameter logic [15:0] EXP_BASE = 16'h0000,
  parameter logic [15:0] EXP_STEP = 16'h0011
) (
  input  logic                        clk,
  input  logic                        reset,
  regfile_readback_checker_if.slave   bus
);

  localparam int unsigned    CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (DWELL > 0) ? CNT_W'(DWELL - 1) : '0;
  localparam logic [5:0]     LAST_IDX  = 6'(NUM_REGS - 1);
  localparam logic [5:0]     NO_FAIL   = 6'h3F;
  localparam logic [4:0]     ERR_MAX   = 5'd31;

  typedef enum logic [2:0] {IDLE, ADDR, CAP, HOLD, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       rnum_q, rnum_d;
  logic [15:0]      result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [4:0]       err_q, err_d;
  logic [5:0]       fail_q, fail_d;

  logic [15:0]      exp_c;
  logic             mismatch_c;
  logic             step_c;

  // Expected value wraps modulo 2^16 by construction of the 16-bit arithmetic.
  assign exp_c      = EXP_BASE + (16'(rnum_q) * EXP_STEP);
  assign mismatch_c = (bus.regReadData != exp_c);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rnum_d   = rnum_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    step_c   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = ADDR;
          rnum_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = NO_FAIL;
        end
      end
      ADDR: state_d = CAP;
      CAP: begin
        result_d = bus.regReadData;
        cnt_d    = '0;
        if (mismatch_c) begin
          if (err_q != ERR_MAX) err_d = 5'(err_q + 5'd1);
          if (fail_q == NO_FAIL) fail_d = rnum_q;
        end
        if (DWELL == 0) step_c = 1'b1;
        else            state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) step_c = 1'b1;
        else                    cnt_d  = CNT_W'(cnt_q + 1'b1);
      end
      default: state_d = IDLE;
    endcase

    // Leaving the per-register window: next register or finish.
    if (step_c) begin
      if (rnum_q < LAST_IDX) begin
        rnum_d  = 6'(rnum_q + 6'd1);
        state_d = ADDR;
      end else begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_d == 5'd0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rnum_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= NO_FAIL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rnum_q   <= rnum_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign bus.regReadNumber = rnum_q;
  assign bus.result        = result_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.errCount      = err_q;
  assign bus.failReg       = fail_q;

endmodule

// File: tb/tb_regfile_readback_checker.sv
// Directed bench: a 4-register/DWELL=2 checker driven from a vector table plus
// hand sequences, and a 40-register/DWELL=0 instance for saturation.
module tb_regfile_readback_checker;

  logic clk;
  logic rst1, rst2;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] model1 [0:63];
  int          rn_hist [0:31];

  regfile_readback_checker_if if1 ();
  regfile_readback_checker_if if2 ();

  regfile_readback_checker #(.NUM_REGS(4), .DWELL(2), .EXP_BASE(16'h0000), .EXP_STEP(16'h0011))
    dut1 (.clk(clk), .reset(rst1), .bus(if1));

  regfile_readback_checker #(.NUM_REGS(40), .DWELL(0), .EXP_BASE(16'h0000), .EXP_STEP(16'h0011))
    dut2 (.clk(clk), .reset(rst2), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register source: data follows regReadNumber one cycle later.
  always @(posedge clk) if1.regReadData <= model1[if1.regReadNumber];
  always @(posedge clk) if2.regReadData <= 16'hFFFF;

  typedef struct packed {
    logic [3:0][15:0] d;
    logic             pass;
    logic [4:0]       err;
    logic [5:0]       fail;
    logic [15:0]      res;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_good();
    for (int i = 0; i < 64; i++) model1[i] = 16'(i * 16'h0011);
  endtask

  // Pulse start on dut1 and return the edge count (after the start edge) at which done rose.
  task automatic scan1(input bit repulse, input bit restart_chk, output int edges);
    edges = -1;
    @(negedge clk); if1.start = 1'b1;
    @(negedge clk); if1.start = 1'b0;
    if (restart_chk) begin
      chk("restart_done", 32'(if1.done), 32'h0);
      chk("restart_pass", 32'(if1.pass), 32'h0);
      chk("restart_err",  32'(if1.errCount), 32'h0);
      chk("restart_rnum", 32'(if1.regReadNumber), 32'h0);
      chk("restart_fail", 32'(if1.failReg), 32'h3F);
      chk("restart_busy", 32'(if1.busy), 32'h1);
    end
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if1.start = repulse && (k == 4);
      if (k < 32) rn_hist[k] = 32'(if1.regReadNumber);
      if (k == 8) begin
        chk("midscan_busy", 32'(if1.busy), 32'h1);
        chk("midscan_pass", 32'(if1.pass), 32'h0);
      end
      if (if1.done) begin
        edges = k;
        break;
      end
    end
    if1.start = 1'b0;
  endtask

  initial begin
    int   edges;
    bit   seen;
    int   vi;

    vecs[0] = '{d: {16'h0033, 16'h0022, 16'h0011, 16'h0000}, pass: 1'b1, err: 5'd0, fail: 6'h3F, res: 16'h0033};
    vecs[1] = '{d: {16'h0000, 16'h0023, 16'h0011, 16'h0000}, pass: 1'b0, err: 5'd2, fail: 6'h02, res: 16'h0000};
    vecs[2] = '{d: {16'h0033, 16'h0022, 16'h0011, 16'hFFFF}, pass: 1'b0, err: 5'd1, fail: 6'h00, res: 16'h0033};
    vecs[3] = '{d: {16'h0034, 16'h0022, 16'h0011, 16'h0000}, pass: 1'b0, err: 5'd1, fail: 6'h03, res: 16'h0034};

    load_good();
    if1.start = 1'b0;
    if2.start = 1'b0;
    rst1 = 1'b1;
    rst2 = 1'b1;

    // Reset values before any clock edge.
    #1;
    chk("rst_rnum",   32'(if1.regReadNumber), 32'h0);
    chk("rst_result", 32'(if1.result), 32'h0);
    chk("rst_busy",   32'(if1.busy), 32'h0);
    chk("rst_done",   32'(if1.done), 32'h0);
    chk("rst_pass",   32'(if1.pass), 32'h0);
    chk("rst_err",    32'(if1.errCount), 32'h0);
    chk("rst_fail",   32'(if1.failReg), 32'h3F);

    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    rst2 = 1'b0;

    // Table-driven scans.
    for (vi = 0; vi < 4; vi++) begin
      for (int r = 0; r < 4; r++) model1[r] = vecs[vi].d[r];
      scan1(1'b0, 1'b0, edges);
      chk("scan_edges", 32'(edges), 32'd16);
      chk("scan_done",  32'(if1.done), 32'h1);
      chk("scan_busy",  32'(if1.busy), 32'h0);
      chk("scan_pass",  32'(if1.pass), 32'(vecs[vi].pass));
      chk("scan_err",   32'(if1.errCount), 32'(vecs[vi].err));
      chk("scan_fail",  32'(if1.failReg), 32'(vecs[vi].fail));
      chk("scan_res",   32'(if1.result), 32'(vecs[vi].res));
      chk("scan_rnum",  32'(if1.regReadNumber), 32'h3);
      if (vi == 0) begin
        chk("rn_k2",  32'(rn_hist[2]),  32'd0);
        chk("rn_k3",  32'(rn_hist[3]),  32'd0);
        chk("rn_k4",  32'(rn_hist[4]),  32'd1);
        chk("rn_k6",  32'(rn_hist[6]),  32'd1);
        chk("rn_k10", 32'(rn_hist[10]), 32'd2);
        chk("rn_k14", 32'(rn_hist[14]), 32'd3);
      end
    end

    // Held in DONE with no start.
    repeat (5) @(negedge clk);
    chk("done_hold",      32'(if1.done), 32'h1);
    chk("done_hold_err",  32'(if1.errCount), 32'h1);
    chk("done_hold_fail", 32'(if1.failReg), 32'h3);

    // Restart from DONE, with a start re-pulse while busy.
    load_good();
    scan1(1'b1, 1'b1, edges);
    chk("repulse_edges", 32'(edges), 32'd16);
    chk("repulse_pass",  32'(if1.pass), 32'h1);
    chk("repulse_err",   32'(if1.errCount), 32'h0);

    // Asynchronous reset mid-scan.
    model1[0] = 16'hFFFF;
    @(negedge clk); if1.start = 1'b1;
    @(negedge clk); if1.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_err", 32'(if1.errCount), 32'h1);
    rst1 = 1'b1;
    #1;
    chk("arst_rnum",   32'(if1.regReadNumber), 32'h0);
    chk("arst_result", 32'(if1.result), 32'h0);
    chk("arst_busy",   32'(if1.busy), 32'h0);
    chk("arst_err",    32'(if1.errCount), 32'h0);
    chk("arst_fail",   32'(if1.failReg), 32'h3F);
    chk("arst_done",   32'(if1.done), 32'h0);
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    seen = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (if1.done || if1.busy) seen = 1'b1;
    end
    chk("idle_after_reset", 32'(seen), 32'h0);
    load_good();
    scan1(1'b0, 1'b0, edges);
    chk("post_rst_edges", 32'(edges), 32'd16);
    chk("post_rst_pass",  32'(if1.pass), 32'h1);

    // Saturation on the 40-register, no-dwell instance.
    edges = -1;
    @(negedge clk); if2.start = 1'b1;
    @(negedge clk); if2.start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (if2.done) begin
        edges = k;
        break;
      end
    end
    chk("sat_edges", 32'(edges), 32'd80);
    chk("sat_err",   32'(if2.errCount), 32'd31);
    chk("sat_fail",  32'(if2.failReg), 32'h0);
    chk("sat_pass",  32'(if2.pass), 32'h0);
    chk("sat_res",   32'(if2.result), 32'hFFFF);
    chk("sat_rnum",  32'(if2.regReadNumber), 32'd39);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_readback_checker.md
REGFILE_READBACK_CHECKER -- requirements
Module: regfile_readback_checker

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of registers scanned (legal 1..63).
REQ-002 SHALL have parameter DWELL, default 50000000, cycles each captured value is held on result (0 = no hold).
REQ-003 SHALL have parameter EXP_BASE, default 16'h0000, expected value of register 0.
REQ-004 SHALL have parameter EXP_STEP, default 16'h0011, expected increment per register index.
REQ-005 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, scan request, sampled on clk.
REQ-008 SHALL have port regReadData, input, 16, register contents for the current regReadNumber, valid one cycle after regReadNumber changes.
REQ-009 SHALL have port regReadNumber, output, 6, register index being read.
REQ-010 SHALL have port result, output, 16, last captured register value, for the LED driver.
REQ-011 SHALL have port busy, output, 1, scan in progress.
REQ-012 SHALL have port done, output, 1, scan complete, held until restart or reset.
REQ-013 SHALL have port pass, output, 1, high with done when zero mismatches occurred.
REQ-014 SHALL have port errCount, output, 5, mismatch count, saturating.
REQ-015 SHALL have port failReg, output, 6, index of first mismatching register, 6'h3F if none.

Function
REQ-016 SHALL implement states IDLE, ADDR, CAP, HOLD, DONE, all outputs registered.
REQ-017 IDLE: start=1 at an edge SHALL clear errCount, set failReg=6'h3F, set index=0, drive regReadNumber=0, enter ADDR; busy=1 from that edge.
REQ-018 ADDR SHALL last exactly one cycle, then enter CAP.
REQ-019 CAP SHALL last one cycle; at its ending edge SHALL load result<=regReadData and compare against expected = (EXP_BASE + index*EXP_STEP) mod 2^16.
REQ-020 On mismatch SHALL increment errCount, saturating at 31, and, if failReg==6'h3F, load failReg<=index.
REQ-021 After CAP SHALL enter HOLD for exactly DWELL cycles; DWELL=0 SHALL skip HOLD.
REQ-022 On leaving HOLD (or CAP when DWELL=0): if index<NUM_REGS-1 SHALL increment index, update regReadNumber, enter ADDR; else enter DONE.
REQ-023 Per-register time SHALL be 2+DWELL cycles; done SHALL rise exactly NUM_REGS*(2+DWELL) edges after the start-sampling edge.
REQ-024 DONE: busy=0, done=1, pass=(errCount==0); result, errCount, failReg and regReadNumber SHALL hold.
REQ-025 start while busy SHALL be ignored.
REQ-026 start in DONE SHALL behave as REQ-017 and clear done and pass on the same edge.
REQ-027 pass SHALL be 0 whenever done is 0.
REQ-028 DWELL counter SHALL be wide enough for the parameter value, with no wrap before DWELL is reached.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, regReadNumber=0, result=16'h0000, busy=0, done=0, pass=0, errCount=0, failReg=6'h3F, independent of clk.
REQ-030 Reset mid-scan SHALL abandon the scan; first edge after release SHALL be treated as IDLE.

Verification (NUM_REGS=4, DWELL=2, EXP_BASE=0, EXP_STEP=16'h0011 unless noted)
REQ-031 Assert reset, no clock -> all outputs at REQ-029 values.
REQ-032 Model returns 0000/0011/0022/0033 for regs 0..3, pulse start -> regReadNumber steps 0,1,2,3 every 4 cycles; done=1 16 edges after start; pass=1, errCount=0, failReg=3F, result=0033.
REQ-033 Regs 2,3 return 0023, 0000 -> done, pass=0, errCount=2, failReg=2, result=0000.
REQ-034 start re-pulsed at cycle 5 -> ignored, done still at edge 16; start in DONE -> done=0 next edge, errCount=0, regReadNumber=0, rescan completes.
REQ-035 reset asserted at cycle 7, released at cycle 9 -> outputs at reset values asynchronously, IDLE afterward, no done until new start.
REQ-036 NUM_REGS=40, DWELL=0, model always returns FFFF -> errCount saturates at 31, failReg=0, done 80 edges after start.
